// File: rtl/vga_timing_if.sv
// Raster timing bundle from the pixel-clock timing generator to its consumers
// (framebuffer read side and colour output stage).
// Handshake: none. The bundle is free-running with no valid/ready pair; every
// signal is a registered, mutually aligned sample of the same raster position
// and is meaningful on every pixel-clock cycle, so consumers never stall it.
interface vga_timing_if #(
   parameter int X_W = 11,
   parameter int Y_W = 10
) ();

   logic           hsync;
   logic           vsync;
   logic           de;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           line_start;
   logic           frame_start;
   logic           win;
   logic [7:0]     gb_x;
   logic [7:0]     gb_y;

   // Timing generator side drives the bundle.
   modport master (
      output hsync, vsync, de, x, y, line_start, frame_start, win, gb_x, gb_y
   );

   // Consumers only observe it.
   modport slave (
      input hsync, vsync, de, x, y, line_start, frame_start, win, gb_x, gb_y
   );

endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator for the GB-to-VGA path.
// Free-running h/v counters produce sync, data-enable, coordinates and
// line/frame strobes; a pair of scale sub-counters maps the raster onto an
// integer-scaled 160x144 Game Boy window without any divider. All outputs are
// registered and describe the counter position of the previous cycle.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int X_W      = 11,
   parameter int Y_W      = 10,
   parameter int GB_W     = 160,
   parameter int GB_H     = 144,
   parameter int SCALE    = 4,
   parameter int WIN_X0   = 80,
   parameter int WIN_Y0   = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sub-counter width; a 1-bit counter is kept even for SCALE==1 so the
   // datapath shape does not change with the parameter.
   localparam int SC_W = (SCALE > 1) ? $clog2(SCALE) : 1;

   // Comparisons run one bit wider than the counters so that a boundary equal
   // to 2**X_W (e.g. sync ending exactly at H_TOTAL) cannot alias to zero.
   localparam int XE = X_W + 1;
   localparam int YE = Y_W + 1;

   localparam logic [XE-1:0] H_LAST = XE'(H_TOTAL - 1);
   localparam logic [XE-1:0] H_ACT  = XE'(H_ACTIVE);
   localparam logic [XE-1:0] HS_ON  = XE'(H_ACTIVE + H_FP);
   localparam logic [XE-1:0] HS_OFF = XE'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XE-1:0] WX_LO  = XE'(WIN_X0);
   localparam logic [XE-1:0] WX_HI  = XE'(WIN_X0 + GB_W * SCALE);

   localparam logic [YE-1:0] V_LAST = YE'(V_TOTAL - 1);
   localparam logic [YE-1:0] V_ACT  = YE'(V_ACTIVE);
   localparam logic [YE-1:0] VS_ON  = YE'(V_ACTIVE + V_FP);
   localparam logic [YE-1:0] VS_OFF = YE'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YE-1:0] WY_LO  = YE'(WIN_Y0);
   localparam logic [YE-1:0] WY_HI  = YE'(WIN_Y0 + GB_H * SCALE);

   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCALE - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   if (SCALE < 1) begin : g_bad_scale
      $fatal(1, "vga_timing_gen: SCALE must be >= 1");
   end
   if (WIN_X0 < 0 || WIN_Y0 < 0) begin : g_bad_origin
      $fatal(1, "vga_timing_gen: window origin must be non-negative");
   end
   if (WIN_X0 + GB_W * SCALE > H_ACTIVE) begin : g_bad_win_w
      $fatal(1, "vga_timing_gen: scaled window exceeds active width");
   end
   if (WIN_Y0 + GB_H * SCALE > V_ACTIVE) begin : g_bad_win_h
      $fatal(1, "vga_timing_gen: scaled window exceeds active height");
   end
   if (H_TOTAL > (1 << X_W)) begin : g_bad_xw
      $fatal(1, "vga_timing_gen: H_TOTAL does not fit in X_W bits");
   end
   if (V_TOTAL > (1 << Y_W)) begin : g_bad_yw
      $fatal(1, "vga_timing_gen: V_TOTAL does not fit in Y_W bits");
   end
   if (GB_W < 1 || GB_W > 256 || GB_H < 1 || GB_H > 256) begin : g_bad_gb
      $fatal(1, "vga_timing_gen: GB_W/GB_H must be within 1..256");
   end

   // ------------------------------------------------------------------
   // Raster position state
   // ------------------------------------------------------------------
   logic [X_W-1:0]  h_cnt;
   logic [Y_W-1:0]  v_cnt;

   // Scale sub-counters and source coordinates for the current position.
   // Once the raster leaves the window they may hold a stale or one-past-end
   // value; the registered outputs are forced to zero there.
   logic [SC_W-1:0] h_sub;
   logic [7:0]      gx;
   logic [SC_W-1:0] v_sub;
   logic [7:0]      gy;

   logic [X_W-1:0]  h_nxt;
   logic [Y_W-1:0]  v_nxt;
   logic [SC_W-1:0] h_sub_nxt;
   logic [7:0]      gx_nxt;
   logic [SC_W-1:0] v_sub_nxt;
   logic [7:0]      gy_nxt;

   logic [XE-1:0]   h_ext;
   logic [YE-1:0]   v_ext;
   logic [XE-1:0]   h_nxt_ext;
   logic [YE-1:0]   v_nxt_ext;
   logic            h_wrap;
   logic            v_wrap;
   logic            in_wx;
   logic            in_wy;
   logic            hs_act;
   logic            vs_act;
   logic            de_cur;

   assign h_ext     = {1'b0, h_cnt};
   assign v_ext     = {1'b0, v_cnt};
   assign h_wrap    = (h_ext == H_LAST);
   assign v_wrap    = (v_ext == V_LAST);
   assign h_nxt_ext = {1'b0, h_nxt};
   assign v_nxt_ext = {1'b0, v_nxt};

   assign in_wx  = (h_ext >= WX_LO) && (h_ext < WX_HI);
   assign in_wy  = (v_ext >= WY_LO) && (v_ext < WY_HI);
   assign hs_act = (h_ext >= HS_ON) && (h_ext < HS_OFF);
   assign vs_act = (v_ext >= VS_ON) && (v_ext < VS_OFF);
   assign de_cur = (h_ext < H_ACT) && (v_ext < V_ACT);

   // Next raster position: h wraps at H_TOTAL-1, v steps on that wrap.
   always_comb begin
      h_nxt = h_cnt + X_W'(1);
      v_nxt = v_cnt;
      if (h_wrap) begin
         h_nxt = '0;
         if (v_wrap) begin
            v_nxt = '0;
         end else begin
            v_nxt = v_cnt + Y_W'(1);
         end
      end
   end

   // Horizontal scale: restart at the window's left edge, otherwise step the
   // sub-counter on every in-window pixel and bump gx when it wraps.
   always_comb begin
      h_sub_nxt = h_sub;
      gx_nxt    = gx;
      if (h_nxt_ext == WX_LO) begin
         h_sub_nxt = '0;
         gx_nxt    = '0;
      end else if (in_wx) begin
         if (h_sub == SC_LAST) begin
            h_sub_nxt = '0;
            gx_nxt    = gx + 8'd1;
         end else begin
            h_sub_nxt = h_sub + SC_W'(1);
         end
      end
   end

   // Vertical scale: only evaluated at the end of a line; restart when the
   // next line is the first window row, otherwise step while in window rows.
   always_comb begin
      v_sub_nxt = v_sub;
      gy_nxt    = gy;
      if (h_wrap) begin
         if (v_nxt_ext == WY_LO) begin
            v_sub_nxt = '0;
            gy_nxt    = '0;
         end else if (in_wy) begin
            if (v_sub == SC_LAST) begin
               v_sub_nxt = '0;
               gy_nxt    = gy + 8'd1;
            end else begin
               v_sub_nxt = v_sub + SC_W'(1);
            end
         end
      end
   end

   // Counter and sub-counter state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
         h_sub <= '0;
         gx    <= '0;
         v_sub <= '0;
         gy    <= '0;
      end else begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
         h_sub <= h_sub_nxt;
         gx    <= gx_nxt;
         v_sub <= v_sub_nxt;
         gy    <= gy_nxt;
      end
   end

   // Output registers: a one-cycle-late, fully aligned view of the position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vid.hsync       <= ~H_POL;
         vid.vsync       <= ~V_POL;
         vid.de          <= 1'b0;
         vid.x           <= '0;
         vid.y           <= '0;
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
         vid.win         <= 1'b0;
         vid.gb_x        <= '0;
         vid.gb_y        <= '0;
      end else begin
         vid.hsync       <= hs_act ? H_POL : ~H_POL;
         vid.vsync       <= vs_act ? V_POL : ~V_POL;
         vid.de          <= de_cur;
         vid.x           <= h_cnt;
         vid.y           <= v_cnt;
         vid.line_start  <= (h_cnt == '0);
         vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
         vid.win         <= in_wx && in_wy;
         vid.gb_x        <= (in_wx && in_wy) ? gx : 8'd0;
         vid.gb_y        <= (in_wx && in_wy) ? gy : 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Four instances run side by side:
// the default 800x600 timing, the 640x480 active-low alternate, and two tiny
// rasters (SCALE=3 and SCALE=1 with a full-screen window) whose whole frames
// fit in a short run. A position-from-cycle-count reference model checks every
// instance on every cycle; a vector table and a few hand sequences pin the
// boundary points.
module tb_vga_timing_gen;

   // ---------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;   // default + alternate instances
   logic rst_s_n;   // small instances

   // ---------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------
   vga_timing_if #(.X_W(11), .Y_W(10)) if_a ();
   vga_timing_if #(.X_W(10), .Y_W(10)) if_b ();
   vga_timing_if #(.X_W(6),  .Y_W(5))  if_c ();
   vga_timing_if #(.X_W(4),  .Y_W(4))  if_d ();

   vga_timing_gen dut_a (.clk(clk), .rst_n(rst_a_n), .vid(if_a));

   vga_timing_gen #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
      .H_POL(1'b0), .V_POL(1'b0), .X_W(10), .Y_W(10),
      .GB_W(160), .GB_H(144), .SCALE(3), .WIN_X0(0), .WIN_Y0(0)
   ) dut_b (.clk(clk), .rst_n(rst_a_n), .vid(if_b));

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .H_POL(1'b1), .V_POL(1'b0), .X_W(6), .Y_W(5),
      .GB_W(5), .GB_H(3), .SCALE(3), .WIN_X0(2), .WIN_Y0(1)
   ) dut_c (.clk(clk), .rst_n(rst_s_n), .vid(if_c));

   vga_timing_gen #(
      .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
      .H_POL(1'b0), .V_POL(1'b1), .X_W(4), .Y_W(4),
      .GB_W(10), .GB_H(8), .SCALE(1), .WIN_X0(0), .WIN_Y0(0)
   ) dut_d (.clk(clk), .rst_n(rst_s_n), .vid(if_d));

   // ---------------------------------------------------------------
   // Observed outputs, normalised to one packed record
   // ---------------------------------------------------------------
   typedef struct packed {
      logic        hsync;
      logic        vsync;
      logic        de;
      logic [10:0] x;
      logic [9:0]  y;
      logic        ls;
      logic        fs;
      logic        win;
      logic [7:0]  gbx;
      logic [7:0]  gby;
   } vid_t;

   vid_t act_a, act_b, act_c, act_d;
   assign act_a = {if_a.hsync, if_a.vsync, if_a.de, if_a.x, if_a.y,
                   if_a.line_start, if_a.frame_start, if_a.win, if_a.gb_x, if_a.gb_y};
   assign act_b = {if_b.hsync, if_b.vsync, if_b.de, 1'b0, if_b.x, if_b.y,
                   if_b.line_start, if_b.frame_start, if_b.win, if_b.gb_x, if_b.gb_y};
   assign act_c = {if_c.hsync, if_c.vsync, if_c.de, 5'b0, if_c.x, 5'b0, if_c.y,
                   if_c.line_start, if_c.frame_start, if_c.win, if_c.gb_x, if_c.gb_y};
   assign act_d = {if_d.hsync, if_d.vsync, if_d.de, 7'b0, if_d.x, 6'b0, if_d.y,
                   if_d.line_start, if_d.frame_start, if_d.win, if_d.gb_x, if_d.gb_y};

   function automatic vid_t pick(input int d);
      case (d)
         0:       return act_a;
         1:       return act_b;
         2:       return act_c;
         default: return act_d;
      endcase
   endfunction

   // ---------------------------------------------------------------
   // Reference model: raster parameters per instance
   // ---------------------------------------------------------------
   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      int hp, vp;
      int gw, gh, sc, wx, wy;
   } cfg_t;

   cfg_t cfg[4];

   // Edges with reset released since the last reset edge, per instance.
   int n_cnt[4] = '{0, 0, 0, 0};
   int cyc = 0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      n_cnt[0] <= rst_a_n ? n_cnt[0] + 1 : 0;
      n_cnt[1] <= rst_a_n ? n_cnt[1] + 1 : 0;
      n_cnt[2] <= rst_s_n ? n_cnt[2] + 1 : 0;
      n_cnt[3] <= rst_s_n ? n_cnt[3] + 1 : 0;
   end

   // Expected outputs after n released edges: position is (n-1) modulo the
   // frame, everything else follows from the raster rules by arithmetic.
   function automatic vid_t model(input int c, input int n);
      vid_t e;
      cfg_t k;
      int   ht, vt, p, h, v;
      logic inw;
      k = cfg[c];
      e = '0;
      e.hsync = (k.hp == 0);
      e.vsync = (k.vp == 0);
      if (n == 0) return e;
      ht  = k.ha + k.hf + k.hs + k.hb;
      vt  = k.va + k.vf + k.vs + k.vb;
      p   = (n - 1) % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      e.hsync = (h >= k.ha + k.hf && h < k.ha + k.hf + k.hs) ? (k.hp != 0) : (k.hp == 0);
      e.vsync = (v >= k.va + k.vf && v < k.va + k.vf + k.vs) ? (k.vp != 0) : (k.vp == 0);
      e.de    = (h < k.ha) && (v < k.va);
      e.x     = 11'(h);
      e.y     = 10'(v);
      e.ls    = (h == 0);
      e.fs    = (p == 0);
      inw     = (h >= k.wx) && (h < k.wx + k.gw * k.sc) &&
                (v >= k.wy) && (v < k.wy + k.gh * k.sc);
      e.win   = inw;
      e.gbx   = inw ? 8'((h - k.wx) / k.sc) : 8'd0;
      e.gby   = inw ? 8'((v - k.wy) / k.sc) : 8'd0;
      return e;
   endfunction

   // ---------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   function automatic string fmt(input vid_t v);
      return $sformatf("hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b win=%0b gb=(%0d,%0d)",
                       v.hsync, v.vsync, v.de, v.x, v.y, v.ls, v.fs, v.win, v.gbx, v.gby);
   endfunction

   task automatic check_vid(input string name, input vid_t got, input vid_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(got), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Every-cycle comparison of all instances against the model.
   logic model_on = 1'b0;
   always @(negedge clk) begin
      if (model_on) begin
         check_vid("model_a", act_a, model(0, n_cnt[0]));
         check_vid("model_b", act_b, model(1, n_cnt[1]));
         check_vid("model_c", act_c, model(2, n_cnt[2]));
         check_vid("model_d", act_d, model(3, n_cnt[3]));
      end
   end

   // ---------------------------------------------------------------
   // Vector table: {instance, frame, x, y} -> expected outputs
   // ---------------------------------------------------------------
   typedef struct {
      int   dut, f, x, y;
      logic hs, vs, de, ls, fs, win;
      int   gbx, gby;
   } vec_t;

   vec_t tab[$];

   task automatic add(input int d, input int f, input int x, input int y,
                      input logic hs, input logic vs, input logic de,
                      input logic ls, input logic fs, input logic win,
                      input int gbx, input int gby);
      vec_t t;
      t = '{d, f, x, y, hs, vs, de, ls, fs, win, gbx, gby};
      tab.push_back(t);
   endtask

   function automatic int vec_time(input vec_t t);
      cfg_t k;
      int   ht, vt;
      k  = cfg[t.dut];
      ht = k.ha + k.hf + k.hs + k.hb;
      vt = k.va + k.vf + k.vs + k.vb;
      return t.f * ht * vt + t.y * ht + t.x;
   endfunction

   // Wait (bounded) until instance d has had exactly n released edges.
   task automatic wait_count(input string name, input int d, input int n, output bit ok);
      int guard;
      guard = 0;
      while (n_cnt[d] != n && guard < 40000) begin
         @(negedge clk);
         guard++;
      end
      ok = (n_cnt[d] == n);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s: wait for count %0d timed out (at %0d)", name, n, n_cnt[d]);
      end
   endtask

   // ---------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------
   initial begin
      vid_t exp_v;
      bit   done[64];
      bit   ok;
      int   t0, t1, guard;

      cfg[0] = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 160, 144, 4, 80, 12};
      cfg[1] = '{640, 16,  96, 48, 480, 10, 2, 33, 0, 0, 160, 144, 3, 0, 0};
      cfg[2] = '{ 20,  3,   4,  5,  12, 1, 2,  3, 1, 0,   5,   3, 3, 2, 1};
      cfg[3] = '{ 10,  2,   3,  1,   8, 1, 1,  2, 0, 1,  10,   8, 1, 0, 0};

      // default 800x600: horizontal edges, line strobe, window mapping
      add(0, 0,   0,  0, 0, 0, 1, 1, 1, 0,   0, 0);
      add(0, 0, 799,  0, 0, 0, 1, 0, 0, 0,   0, 0);
      add(0, 0, 800,  0, 0, 0, 0, 0, 0, 0,   0, 0);
      add(0, 0, 839,  0, 0, 0, 0, 0, 0, 0,   0, 0);
      add(0, 0, 840,  0, 1, 0, 0, 0, 0, 0,   0, 0);
      add(0, 0, 967,  0, 1, 0, 0, 0, 0, 0,   0, 0);
      add(0, 0, 968,  0, 0, 0, 0, 0, 0, 0,   0, 0);
      add(0, 0,   0,  1, 0, 0, 1, 1, 0, 0,   0, 0);
      add(0, 0,  79, 12, 0, 0, 1, 0, 0, 0,   0, 0);
      add(0, 0,  80, 12, 0, 0, 1, 0, 0, 1,   0, 0);
      add(0, 0,  83, 12, 0, 0, 1, 0, 0, 1,   0, 0);
      add(0, 0,  84, 12, 0, 0, 1, 0, 0, 1,   1, 0);
      add(0, 0, 720, 12, 0, 0, 1, 0, 0, 0,   0, 0);
      add(0, 0, 719, 15, 0, 0, 1, 0, 0, 1, 159, 0);
      add(0, 0,  80, 16, 0, 0, 1, 0, 0, 1,   0, 1);
      add(0, 0, 400, 17, 0, 0, 1, 0, 0, 1,  80, 1);
      // alternate 640x480, active-low syncs, SCALE=3 window at origin
      add(1, 0,   0,  0, 1, 1, 1, 1, 1, 1,   0, 0);
      add(1, 0, 476,  0, 1, 1, 1, 0, 0, 1, 158, 0);
      add(1, 0, 477,  0, 1, 1, 1, 0, 0, 1, 159, 0);
      add(1, 0, 479,  0, 1, 1, 1, 0, 0, 1, 159, 0);
      add(1, 0, 480,  0, 1, 1, 1, 0, 0, 0,   0, 0);
      add(1, 0, 640,  0, 1, 1, 0, 0, 0, 0,   0, 0);
      add(1, 0, 655,  0, 1, 1, 0, 0, 0, 0,   0, 0);
      add(1, 0, 656,  0, 0, 1, 0, 0, 0, 0,   0, 0);
      add(1, 0, 751,  0, 0, 1, 0, 0, 0, 0,   0, 0);
      add(1, 0, 752,  0, 1, 1, 0, 0, 0, 0,   0, 0);
      add(1, 0,   0,  1, 1, 1, 1, 1, 0, 1,   0, 0);
      add(1, 0,   5,  3, 1, 1, 1, 0, 0, 1,   1, 1);
      // small SCALE=3 raster: vsync rows, window edges, second frame
      add(2, 0,   0,  0, 0, 1, 1, 1, 1, 0,   0, 0);
      add(2, 0,  23,  1, 1, 1, 0, 0, 0, 0,   0, 0);
      add(2, 0,  16,  9, 0, 1, 1, 0, 0, 1,   4, 2);
      add(2, 0,  17,  9, 0, 1, 1, 0, 0, 0,   0, 0);
      add(2, 0,   2, 10, 0, 1, 1, 0, 0, 0,   0, 0);
      add(2, 0,   0, 13, 0, 0, 0, 1, 0, 0,   0, 0);
      add(2, 0,  31, 14, 0, 0, 0, 0, 0, 0,   0, 0);
      add(2, 0,   0, 15, 0, 1, 0, 1, 0, 0,   0, 0);
      add(2, 1,   0,  0, 0, 1, 1, 1, 1, 0,   0, 0);
      // small SCALE=1 raster with window filling the active area
      add(3, 0,   0,  0, 1, 0, 1, 1, 1, 1,   0, 0);
      add(3, 0,   5,  2, 1, 0, 1, 0, 0, 1,   5, 2);
      add(3, 0,   9,  7, 1, 0, 1, 0, 0, 1,   9, 7);
      add(3, 0,  10,  7, 1, 0, 0, 0, 0, 0,   0, 0);
      add(3, 0,   0,  9, 1, 1, 0, 1, 0, 0,   0, 0);
      add(3, 0,  12,  9, 0, 1, 0, 0, 0, 0,   0, 0);
      add(3, 1,   0,  0, 1, 0, 1, 1, 1, 1,   0, 0);

      // Reset held for 5 cycles: reset values on every instance.
      rst_a_n  = 1'b0;
      rst_s_n  = 1'b0;
      model_on = 1'b1;
      repeat (5) @(negedge clk);
      check_vid("reset_hold_a", act_a, vid_t'(0));
      exp_v = '0;
      exp_v.hsync = 1'b1;
      exp_v.vsync = 1'b1;
      check_vid("reset_hold_b", act_b, exp_v);

      // Release all instances together and walk the table in time order.
      rst_a_n = 1'b1;
      rst_s_n = 1'b1;
      for (int i = 0; i < 64; i++) done[i] = 1'b0;
      for (int k = 0; k < tab.size(); k++) begin
         int mi;
         mi = -1;
         for (int i = 0; i < tab.size(); i++) begin
            if (!done[i] && (mi < 0 || vec_time(tab[i]) < vec_time(tab[mi]))) mi = i;
         end
         done[mi] = 1'b1;
         wait_count($sformatf("vec%0d", mi), tab[mi].dut, vec_time(tab[mi]) + 1, ok);
         if (ok) begin
            exp_v       = '0;
            exp_v.hsync = tab[mi].hs;
            exp_v.vsync = tab[mi].vs;
            exp_v.de    = tab[mi].de;
            exp_v.x     = 11'(tab[mi].x);
            exp_v.y     = 10'(tab[mi].y);
            exp_v.ls    = tab[mi].ls;
            exp_v.fs    = tab[mi].fs;
            exp_v.win   = tab[mi].win;
            exp_v.gbx   = 8'(tab[mi].gbx);
            exp_v.gby   = 8'(tab[mi].gby);
            check_vid($sformatf("vec%0d_dut%0d", mi, tab[mi].dut), pick(tab[mi].dut), exp_v);
         end
      end

      // Mid-frame reset on the default raster at (500,17) for one cycle.
      wait_count("midreset_wait", 0, 17 * 1056 + 500 + 1, ok);
      rst_a_n = 1'b0;
      @(negedge clk);
      check_vid("midreset_values", act_a, vid_t'(0));
      rst_a_n = 1'b1;
      @(negedge clk);
      exp_v    = '0;
      exp_v.de = 1'b1;
      exp_v.ls = 1'b1;
      exp_v.fs = 1'b1;
      check_vid("midreset_restart", act_a, exp_v);
      @(negedge clk);
      exp_v.x  = 11'd1;
      exp_v.ls = 1'b0;
      exp_v.fs = 1'b0;
      check_vid("midreset_step", act_a, exp_v);

      // Random reset pulses on the small rasters; the model tracks them.
      for (int r = 0; r < 20; r++) begin
         repeat ($urandom_range(1, 700)) @(negedge clk);
         rst_s_n = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst_s_n = 1'b1;
      end

      // Frame period of the SCALE=3 raster measured between frame strobes.
      guard = 0;
      while (!if_c.frame_start && guard < 700) begin @(negedge clk); guard++; end
      t0 = cyc;
      @(negedge clk);
      guard = 0;
      while (!if_c.frame_start && guard < 700) begin @(negedge clk); guard++; end
      t1 = cyc;
      check_int("frame_period_c", t1 - t0, 32 * 18);

      // Same for the SCALE=1 raster.
      guard = 0;
      while (!if_d.frame_start && guard < 300) begin @(negedge clk); guard++; end
      t0 = cyc;
      @(negedge clk);
      guard = 0;
      while (!if_d.frame_start && guard < 300) begin @(negedge clk); guard++; end
      t1 = cyc;
      check_int("frame_period_d", t1 - t0, 16 * 12);

      model_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
